// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB3 bus bundle for apb_master_bridge.
// The master modport is the bridge side; slave is the upstream/completer side.
interface apb_master_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns single valid/ready commands into SETUP/ACCESS transfers
// and returns one response per command, aborting hung transfers after TIMEOUT cycles.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                  pclk,
    input logic                  preset,
    apb_master_bridge_if.master  bus
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] tcnt_q;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;
    logic            pwrite_q;
    logic            psel_q;
    logic            penable_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;
    logic            rsp_timeout_q;
    logic            timeout_hit;

    // tcnt_q holds the number of wait cycles already spent, so the Nth ACCESS
    // cycle without pready is the one that aborts.
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == CntLast);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= StIdle;
            tcnt_q        <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        state_q  <= StSetup;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        pwrite_q <= bus.cmd_write;
                        psel_q   <= 1'b1;
                        tcnt_q   <= '0;
                    end
                end
                StSetup: begin
                    state_q   <= StAccess;
                    penable_q <= 1'b1;
                end
                StAccess: begin
                    // pready wins over a timeout landing in the same cycle.
                    if (bus.pready) begin
                        state_q       <= StResp;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? 32'h0 : bus.prdata;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q       <= StResp;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: commands push expected transfers,
// a bus monitor checks phases/timing and pops on each response handshake.
module tb_apb_master_bridge;

    localparam int unsigned TO_N = 4;

    logic pclk;
    logic preset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    apb_master_bridge_if bus ();

    apb_master_bridge #(.TIMEOUT(TO_N)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        logic        se;
        int          n_access;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } txn_t;

    txn_t sb[$];
    int   rise_q[$];
    int   acc_cyc;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Completer: raises pready on ACCESS cycle waits+1; junk data otherwise.
    initial begin : completer
        int a_cnt;
        a_cnt       = 0;
        bus.pready  = 1'b0;
        bus.prdata  = 32'hBAD0_BAD0;
        bus.pslverr = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            if (!preset && bus.psel && bus.penable && sb.size() != 0) begin
                a_cnt++;
                bus.pready  = (a_cnt == sb[0].waits + 1);
                bus.prdata  = bus.pready ? sb[0].rd : 32'hBAD0_BAD0;
                bus.pslverr = bus.pready ? sb[0].se : 1'b1;
            end else begin
                a_cnt       = 0;
                bus.pready  = 1'b0;
                bus.prdata  = 32'hBAD0_BAD0;
                bus.pslverr = 1'b1;
            end
        end
    end

    initial begin : monitor
        int   acc_n;
        logic en_prev;
        logic sel_prev;
        logic vld_prev;
        acc_n    = 0;
        en_prev  = 1'b0;
        sel_prev = 1'b0;
        vld_prev = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                sb.delete();
                acc_n    = 0;
                en_prev  = 1'b0;
                sel_prev = 1'b0;
                vld_prev = 1'b0;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
                if (bus.psel && !sel_prev) rise_q.push_back(cyc);
                if (bus.psel) begin
                    check_eq("psel_pending", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        check_eq("paddr", bus.paddr, sb[0].addr);
                        check_eq("pwrite", bus.pwrite, sb[0].w);
                        if (sb[0].w) check_eq("pwdata", bus.pwdata, sb[0].wdata);
                        if (!bus.penable) check_eq("setup_cyc", 32'(cyc - acc_cyc), 1);
                        else if (!en_prev) check_eq("access_cyc", 32'(cyc - acc_cyc), 2);
                    end
                end
                if (bus.penable) begin
                    acc_n++;
                end else if (en_prev) begin
                    if (sb.size() != 0) check_eq("access_len", 32'(acc_n), 32'(sb[0].n_access));
                    acc_n = 0;
                end
                if (bus.rsp_valid) begin
                    check_eq("rsp_pending", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        if (!vld_prev) check_eq("rsp_lat", 32'(cyc - acc_cyc), 32'(sb[0].lat));
                        check_eq("rsp_rdata", bus.rsp_rdata, sb[0].exp_rdata);
                        check_eq("rsp_err", bus.rsp_err, sb[0].exp_err);
                        check_eq("rsp_timeout", bus.rsp_timeout, sb[0].exp_to);
                        if (bus.rsp_ready) void'(sb.pop_front());
                    end
                end
                en_prev  = bus.penable;
                sel_prev = bus.psel;
                vld_prev = bus.rsp_valid;
            end
        end
    end

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input int waits, input logic [31:0] rd, input logic se);
        txn_t t;
        logic to;
        to          = (TO_N != 0) && (waits >= int'(TO_N));
        t.w         = w;
        t.addr      = a;
        t.wdata     = d;
        t.rd        = rd;
        t.waits     = waits;
        t.se        = se;
        t.n_access  = to ? int'(TO_N) : waits + 1;
        t.lat       = t.n_access + 2;
        t.exp_rdata = (to || w) ? 32'h0 : rd;
        t.exp_err   = to | se;
        t.exp_to    = to;
        sb.push_back(t);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge pclk);
        while (!bus.cmd_ready && k < 50) begin
            @(negedge pclk);
            k++;
        end
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'hFFFF_FFFF;
        bus.cmd_wdata = 32'hFFFF_FFFF;
        check_eq("accept_wait", 32'(k < 50), 1);
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input logic se);
        drive_cmd(w, a, d, waits, rd, se);
        wait_accept();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge pclk);
        while ((sb.size() != 0 || !bus.cmd_ready) && k < 100) begin
            @(negedge pclk);
            k++;
        end
        check_eq("done_wait", 32'(sb.size()), 0);
        @(posedge pclk);
        #1;
    endtask

    task automatic check_idle_values(input string pfx);
        check_eq({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        check_eq({pfx, "_psel"}, bus.psel, 0);
        check_eq({pfx, "_penable"}, bus.penable, 0);
        check_eq({pfx, "_pwrite"}, bus.pwrite, 0);
        check_eq({pfx, "_paddr"}, bus.paddr, 0);
        check_eq({pfx, "_pwdata"}, bus.pwdata, 0);
        check_eq({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({pfx, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check_eq({pfx, "_rsp_err"}, bus.rsp_err, 0);
        check_eq({pfx, "_rsp_timeout"}, bus.rsp_timeout, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        cyc           = 0;
        n_tests       = 0;
        n_fail        = 0;
        acc_cyc       = 0;
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check_idle_values("reset");
        preset = 1'b0;
        @(negedge pclk);
        check_idle_values("post_reset");
        @(posedge pclk);
        #1;

        // zero-wait write, 3-wait read, slave errors
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        wait_done();
        send(1'b0, 32'h0000_0024, 32'h0, 3, 32'h1234_5678, 1'b0);
        wait_done();
        send(1'b0, 32'h0000_0030, 32'h0, 1, 32'h0000_CAFE, 1'b1);
        wait_done();
        send(1'b1, 32'h0000_0034, 32'h5555_AAAA, 2, 32'h7777_7777, 1'b1);
        wait_done();

        // timeout, then a normal follow-up
        send(1'b0, 32'h0000_0040, 32'h0, 99, 32'h9999_9999, 1'b0);
        wait_done();
        send(1'b0, 32'h0000_0044, 32'h0, 0, 32'hA5A5_5A5A, 1'b0);
        wait_done();

        // backpressure with a queued command
        bus.rsp_ready = 1'b0;
        send(1'b0, 32'h0000_0050, 32'h0, 1, 32'h1111_2222, 1'b0);
        k = 0;
        @(negedge pclk);
        while (!bus.rsp_valid && k < 50) begin
            @(negedge pclk);
            k++;
        end
        check_eq("rsp_wait", 32'(k < 50), 1);
        @(posedge pclk);
        #1;
        drive_cmd(1'b1, 32'h0000_0054, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        repeat (5) begin
            @(negedge pclk);
            check_eq("bp_cmd_ready", bus.cmd_ready, 0);
            check_eq("bp_psel", bus.psel, 0);
            check_eq("bp_rsp_valid", bus.rsp_valid, 1);
        end
        @(posedge pclk);
        #1;
        rise_q.delete();
        bus.rsp_ready = 1'b1;
        wait_accept();
        send(1'b0, 32'h0000_0058, 32'h0, 0, 32'hC0DE_0001, 1'b0);
        send(1'b1, 32'h0000_005C, 32'hFEED_0002, 0, 32'h0, 1'b0);
        send(1'b0, 32'h0000_0060, 32'h0, 0, 32'hC0DE_0003, 1'b0);
        wait_done();
        check_eq("b2b_rises", 32'(rise_q.size()), 4);
        for (int i = 1; i < rise_q.size(); i++) begin
            check_eq("b2b_gap", 32'(rise_q[i] - rise_q[i-1]), 4);
        end

        // asynchronous reset during an ACCESS wait state
        send(1'b0, 32'h0000_0064, 32'h0, 99, 32'h4444_4444, 1'b0);
        @(posedge pclk);
        #1;
        check_eq("pre_rst_penable", bus.penable, 1);
        #2;
        preset = 1'b1;
        #1;
        check_eq("async_psel", bus.psel, 0);
        check_eq("async_penable", bus.penable, 0);
        #3;
        preset = 1'b0;
        @(negedge pclk);
        check_idle_values("mid_reset");
        repeat (4) begin
            @(negedge pclk);
            check_eq("stale_rsp_valid", bus.rsp_valid, 0);
        end
        @(posedge pclk);
        #1;
        send(1'b0, 32'h0000_0070, 32'h0, 0, 32'h0F0F_F0F0, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
